// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV64 core widths, register address type and write-port record
// Shared by the register-file write scheduler and its busy-bit scoreboard.
package rv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xdata_t;

  // One register-file write-port request.
  typedef struct packed {
    logic      we;
    reg_addr_t wa;
    xdata_t    wd;
  } rf_wr_t;

  // Decoded one-hot select with x0 masked off, since x0 is never tracked.
  function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t a);
    logic [NREG-1:0] oh;
    oh = NREG'(1) << a;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/regwrite_busy_vec.sv
// rtl/regwrite_busy_vec.sv - per-register busy bits with set/clear and read-before-write lookups
// All lookups see the value from before this cycle's set/clear; x0 always reads as not busy.
module regwrite_busy_vec
  import rv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  input  logic [REG_AW-1:0]   rs1_addr,
  input  logic [REG_AW-1:0]   rs2_addr,
  input  logic [REG_AW-1:0]   waw_addr,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                waw_busy,
  output logic                clr_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask = reg_onehot(set_addr);
    if (clr_en) clr_mask = reg_onehot(clr_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  assign rs1_busy = (rs1_addr != '0) & busy[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) & busy[rs2_addr];
  assign waw_busy = (waw_addr != '0) & busy[waw_addr];
  assign clr_busy = (clr_addr != '0) & busy[clr_addr];

endmodule

// File: rtl/regwrite_scheduler.sv
// rtl/regwrite_scheduler.sv - register-file write-port arbiter and long-latency scoreboard
// ALU writeback always owns the port; long-latency results wait on ll_ready and clear busy bits.
module regwrite_scheduler
  import rv_pkg::*;
#(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic              iss_rs1_used,
  input  logic              iss_rs2_used,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_rd_we,
  input  logic              iss_long,
  output logic              iss_stall,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_addr,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              ll_valid,
  input  logic [REG_AW-1:0] ll_addr,
  input  logic [XLEN-1:0]   ll_data,
  output logic              ll_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic              ll_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] OUT_FULL   = CW'(MAX_OUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [CW-1:0] out_cnt;
  logic [SW-1:0] starve_cnt;
  logic          err_q;

  logic rs1_busy, rs2_busy, rd_busy, ll_busy;
  logic hazard, iss_fire, ll_fire, set_en, cnt_inc, cnt_dec, ll_bad;
  rf_wr_t wr;

  regwrite_busy_vec u_busy (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_addr (iss_rd),
    .clr_en   (ll_fire),
    .clr_addr (ll_addr),
    .rs1_addr (iss_rs1),
    .rs2_addr (iss_rs2),
    .waw_addr (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .waw_busy (rd_busy),
    .clr_busy (ll_busy)
  );

  always_comb begin
    hazard = (iss_rs1_used & rs1_busy)
           | (iss_rs2_used & rs2_busy)
           | (iss_rd_we & rd_busy)
           | (iss_long & (out_cnt == OUT_FULL))
           | (starve_cnt == STARVE_MAX);
  end

  assign iss_stall = iss_valid & (rst | hazard);
  assign iss_fire  = iss_valid & ~iss_stall;
  assign ll_ready  = ~rst & ~alu_wb_valid;
  assign ll_fire   = ll_valid & ll_ready;

  // out_cnt tracks every expected ll return, including ones whose result is dropped.
  assign set_en  = iss_fire & iss_long & iss_rd_we & (iss_rd != '0);
  assign cnt_inc = iss_fire & iss_long;
  assign cnt_dec = ll_fire & (out_cnt != '0);
  assign ll_bad  = ll_fire & (((ll_addr != '0) & ~ll_busy) | (out_cnt == '0));

  always_comb begin
    wr = '0;
    if (!rst) begin
      if (alu_wb_valid) begin
        wr.we = (alu_wb_addr != '0);
        wr.wa = alu_wb_addr;
        wr.wd = alu_wb_data;
      end else if (ll_valid) begin
        wr.we = (ll_addr != '0);
        wr.wa = ll_addr;
        wr.wd = ll_data;
      end
    end
  end

  assign rf_we = wr.we;
  assign rf_wa = wr.wa;
  assign rf_wd = wr.wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt    <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      // A pending result that keeps losing to ALU writeback eventually forces a bubble.
      if (ll_fire || !ll_valid) begin
        starve_cnt <= '0;
      end else if (alu_wb_valid && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      err_q <= err_q | ll_bad;
    end
  end

  assign ll_err = err_q;

endmodule
